// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller with a tear-free load handshake.
// A captured value waits in a shadow register and is committed only at the end of a full scan frame.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [7:0]  digit_mask,
    output logic        busy,
    output logic        load_ack,
    output logic [6:0]  out7,
    output logic [7:0]  en_out
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    typedef enum logic [1:0] {
        OUT_DARK  = 2'd0,
        OUT_BLANK = 2'd1,
        OUT_LIT   = 2'd2
    } out_state_t;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       dig_q, dig_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      disp_q, disp_d;
    logic             pending_q, pending_d;
    logic             load_ack_q, load_ack_d;

    out_state_t       out_state_q, out_state_d;
    logic [2:0]       out_dig_q, out_dig_d;
    logic [6:0]       out_seg_q, out_seg_d;

    logic             tick;
    logic             frame_end;
    logic [3:0]       cur_nib;
    logic [7:0]       lz_blank_vec;
    logic [7:0]       dig_onehot;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Scan timing: prescaler and digit index
    assign tick      = (pre_q == PRE_LAST);
    assign frame_end = tick && (dig_q == 3'd7);

    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_ONE;
        dig_d = tick ? dig_q + 3'd1 : dig_q;
    end

    // Commit takes priority; while pending any new load is simply ignored.
    always_comb begin
        shadow_d   = shadow_q;
        disp_d     = disp_q;
        pending_d  = pending_q;
        load_ack_d = 1'b0;
        if (frame_end && pending_q) begin
            disp_d     = shadow_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end else if (load && !pending_q) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            dig_q      <= 3'd0;
            shadow_q   <= 32'd0;
            disp_q     <= 32'd0;
            pending_q  <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            dig_q      <= dig_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            pending_q  <= pending_d;
            load_ack_q <= load_ack_d;
        end
    end

    assign busy     = pending_q;
    assign load_ack = load_ack_q;

    // Digit i is a leading zero when it and every more-significant nibble is zero.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lz
            if (gi == 0) begin : g_first
                assign lz_blank_vec[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank_vec[gi] = blank_lz && (disp_q[31:4*gi] == '0);
            end
        end
    endgenerate

    assign cur_nib = disp_q[{dig_q, 2'b00} +: 4];

    // Output state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_state_q <= OUT_DARK;
            out_dig_q   <= 3'd0;
            out_seg_q   <= 7'h7F;
        end else begin
            out_state_q <= out_state_d;
            out_dig_q   <= out_dig_d;
            out_seg_q   <= out_seg_d;
        end
    end

    // Output next state: classify the digit currently addressed by the scan.
    always_comb begin
        out_dig_d = dig_q;
        out_seg_d = seg_decode(cur_nib);
        if (!digit_mask[dig_q]) begin
            out_state_d = OUT_DARK;
        end else if (lz_blank_vec[dig_q]) begin
            out_state_d = OUT_BLANK;
        end else begin
            out_state_d = OUT_LIT;
        end
    end

    generate
        for (gi = 0; gi < 8; gi++) begin : g_onehot
            assign dig_onehot[gi] = (out_dig_q == 3'(gi));
        end
    endgenerate

    // Output decode
    always_comb begin
        out7   = 7'h7F;
        en_out = 8'hFF;
        case (out_state_q)
            OUT_BLANK: begin
                en_out = ~dig_onehot;
            end
            OUT_LIT: begin
                en_out = ~dig_onehot;
                out7   = out_seg_q;
            end
            default: begin
                out7   = 7'h7F;
                en_out = 8'hFF;
            end
        endcase
    end

endmodule
